// File: rtl/regfile_dual_wb_if.sv
// Register-file port bundle: four decode read ports, two writeback write ports and the collision flag.
// The regfile side uses the slave modport; the decode/writeback side uses master.
interface regfile_dual_wb_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5
);
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_0;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_0;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_1;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_1;
  logic [DATA_WIDTH-1:0]    RF_Rs1Data_0;
  logic [DATA_WIDTH-1:0]    RF_Rs2Data_0;
  logic [DATA_WIDTH-1:0]    RF_Rs1Data_1;
  logic [DATA_WIDTH-1:0]    RF_Rs2Data_1;
  logic [RF_ADDR_WIDTH-1:0] MemWb_RdAddr_0;
  logic                     MemWb_RdWrtEn_0;
  logic [DATA_WIDTH-1:0]    Wb_DataWrt_0;
  logic [RF_ADDR_WIDTH-1:0] MemWb_RdAddr_1;
  logic                     MemWb_RdWrtEn_1;
  logic [DATA_WIDTH-1:0]    Wb_DataWrt_1;
  logic                     RF_WrtCollision;

  modport slave (
    input  Decode_Rs1Addr_0, Decode_Rs2Addr_0, Decode_Rs1Addr_1, Decode_Rs2Addr_1,
    input  MemWb_RdAddr_0, MemWb_RdWrtEn_0, Wb_DataWrt_0,
    input  MemWb_RdAddr_1, MemWb_RdWrtEn_1, Wb_DataWrt_1,
    output RF_Rs1Data_0, RF_Rs2Data_0, RF_Rs1Data_1, RF_Rs2Data_1,
    output RF_WrtCollision
  );

  modport master (
    output Decode_Rs1Addr_0, Decode_Rs2Addr_0, Decode_Rs1Addr_1, Decode_Rs2Addr_1,
    output MemWb_RdAddr_0, MemWb_RdWrtEn_0, Wb_DataWrt_0,
    output MemWb_RdAddr_1, MemWb_RdWrtEn_1, Wb_DataWrt_1,
    input  RF_Rs1Data_0, RF_Rs2Data_0, RF_Rs1Data_1, RF_Rs2Data_1,
    input  RF_WrtCollision
  );
endinterface

// File: rtl/regfile_dual_wb.sv
// Dual-issue integer register file: 4 async read ports, 2 sync write ports, x0 hardwired to zero.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module regfile_dual_wb #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned RF_NUM        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_dual_wb_if.slave       rf_if
);

  localparam int unsigned NUM_RD_PORTS = 4;

  logic [DATA_WIDTH-1:0]    regs_q   [1:RF_NUM-1];
  logic [DATA_WIDTH-1:0]    regs_d   [1:RF_NUM-1];
  logic                     wen_c    [1:RF_NUM-1];
  logic                     sel1_c   [1:RF_NUM-1];
  logic [DATA_WIDTH-1:0]    rd_view_c[RF_NUM];
  logic [RF_ADDR_WIDTH-1:0] ra_c     [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0]    rdata_c  [NUM_RD_PORTS];
  logic                     wrt_collision_q;
  logic                     wrt_collision_d;
  logic                     wr_active_0_c;
  logic                     wr_active_1_c;

  // Write qualification: an enabled write to x0 is a no-op.
  always_comb begin
    wr_active_0_c = rf_if.MemWb_RdWrtEn_0 & (rf_if.MemWb_RdAddr_0 != '0);
    wr_active_1_c = rf_if.MemWb_RdWrtEn_1 & (rf_if.MemWb_RdAddr_1 != '0);
  end

  // Per-register write decode; slot 1 (younger) wins a same-rd collision.
  always_comb begin
    for (int unsigned i = 1; i < RF_NUM; i++) begin
      sel1_c[i] = rf_if.MemWb_RdWrtEn_1 & (rf_if.MemWb_RdAddr_1 == RF_ADDR_WIDTH'(i));
      wen_c[i]  = (rf_if.MemWb_RdWrtEn_0 & (rf_if.MemWb_RdAddr_0 == RF_ADDR_WIDTH'(i)))
                | sel1_c[i];
      regs_d[i] = regs_q[i];
      if (wen_c[i]) begin
        regs_d[i] = sel1_c[i] ? rf_if.Wb_DataWrt_1 : rf_if.Wb_DataWrt_0;
      end
    end
  end

  always_comb begin
    wrt_collision_d = wr_active_0_c & wr_active_1_c
                    & (rf_if.MemWb_RdAddr_0 == rf_if.MemWb_RdAddr_1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < RF_NUM; i++) begin
        regs_q[i] <= '0;
      end
      wrt_collision_q <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < RF_NUM; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wrt_collision_q <= wrt_collision_d;
    end
  end

  // Flat read view with x0 as a constant zero entry.
  always_comb begin
    rd_view_c[0] = '0;
    for (int unsigned i = 1; i < RF_NUM; i++) begin
      rd_view_c[i] = regs_q[i];
    end
  end

  always_comb begin
    ra_c[0] = rf_if.Decode_Rs1Addr_0;
    ra_c[1] = rf_if.Decode_Rs2Addr_0;
    ra_c[2] = rf_if.Decode_Rs1Addr_1;
    ra_c[3] = rf_if.Decode_Rs2Addr_1;
  end

  // Read mux; with bypass enabled, in-flight write data overrides the stored value.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      rdata_c[p] = rd_view_c[ra_c[p]];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_active_1_c && (rf_if.MemWb_RdAddr_1 == ra_c[p])) begin
        rdata_c[p] = rf_if.Wb_DataWrt_1;
      end else if (wr_active_0_c && (rf_if.MemWb_RdAddr_0 == ra_c[p])) begin
        rdata_c[p] = rf_if.Wb_DataWrt_0;
      end
`endif
    end
  end

  assign rf_if.RF_Rs1Data_0    = rdata_c[0];
  assign rf_if.RF_Rs2Data_0    = rdata_c[1];
  assign rf_if.RF_Rs1Data_1    = rdata_c[2];
  assign rf_if.RF_Rs2Data_1    = rdata_c[3];
  assign rf_if.RF_WrtCollision = wrt_collision_q;

endmodule

// File: tb/tb_regfile_dual_wb.sv
// Self-checking bench for regfile_dual_wb: directed cases plus random traffic against an array model.
module tb_regfile_dual_wb;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] model [32];
  logic        coll_exp;

  regfile_dual_wb_if bus ();

  regfile_dual_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value from the architectural model, seen before the coming edge.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
    if (bus.MemWb_RdWrtEn_1 && bus.MemWb_RdAddr_1 == a) return bus.Wb_DataWrt_1;
    if (bus.MemWb_RdWrtEn_0 && bus.MemWb_RdAddr_0 == a) return bus.Wb_DataWrt_0;
`endif
    return model[a];
  endfunction

  task automatic set_reads(input logic [4:0] r0, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] r3);
    bus.Decode_Rs1Addr_0 = r0;
    bus.Decode_Rs2Addr_0 = r1;
    bus.Decode_Rs1Addr_1 = r2;
    bus.Decode_Rs2Addr_1 = r3;
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, ".rs1_0"}, bus.RF_Rs1Data_0, exp_rd(bus.Decode_Rs1Addr_0));
    check({tag, ".rs2_0"}, bus.RF_Rs2Data_0, exp_rd(bus.Decode_Rs2Addr_0));
    check({tag, ".rs1_1"}, bus.RF_Rs1Data_1, exp_rd(bus.Decode_Rs1Addr_1));
    check({tag, ".rs2_1"}, bus.RF_Rs2Data_1, exp_rd(bus.Decode_Rs2Addr_1));
  endtask

  // One cycle: drive writes and reads, check reads pre-edge, update model, check flag post-edge.
  task automatic do_cycle(input string tag,
                          input logic en0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic en1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] r0, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] r3);
    bus.MemWb_RdWrtEn_0 = en0; bus.MemWb_RdAddr_0 = a0; bus.Wb_DataWrt_0 = d0;
    bus.MemWb_RdWrtEn_1 = en1; bus.MemWb_RdAddr_1 = a1; bus.Wb_DataWrt_1 = d1;
    set_reads(r0, r1, r2, r3);
    check_reads(tag);
    @(posedge clk);
    if (en0 && a0 != 5'd0) model[a0] = d0;
    if (en1 && a1 != 5'd0) model[a1] = d1;
    coll_exp = en0 && en1 && (a0 == a1) && (a0 != 5'd0);
    #1;
    check({tag, ".coll"}, 32'(bus.RF_WrtCollision), 32'(coll_exp));
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [4:0] r0, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] r3);
    do_cycle(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r0, r1, r2, r3);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    coll_exp = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    bus.MemWb_RdWrtEn_0 = 1'b0; bus.MemWb_RdAddr_0 = '0; bus.Wb_DataWrt_0 = '0;
    bus.MemWb_RdWrtEn_1 = 1'b0; bus.MemWb_RdAddr_1 = '0; bus.Wb_DataWrt_1 = '0;
    set_reads(5'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("reset.coll", 32'(bus.RF_WrtCollision), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3));
      check_reads("reset_rd");
    end
    check("reset_rel.coll", 32'(bus.RF_WrtCollision), 32'h0);

    do_cycle("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 5'd6, 5'd5);
    idle("wr5_rd", 5'd5, 5'd4, 5'd6, 5'd5);
    check("wr5.literal", bus.RF_Rs1Data_0, 32'hDEADBEEF);

    do_cycle("x0wr", 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 5'd0);
    idle("x0_rd", 5'd0, 5'd0, 5'd0, 5'd0);

    do_cycle("coll7", 1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd7, 5'd7);
    idle("coll7_rd", 5'd7, 5'd7, 5'd7, 5'd7);
    check("coll7.literal", bus.RF_Rs2Data_1, 32'h22222222);

    do_cycle("dual", 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4, 32'h5A5A5A5A, 5'd3, 5'd4, 5'd3, 5'd4);
    idle("dual_rd", 5'd3, 5'd4, 5'd4, 5'd3);

    do_cycle("x9_init", 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, 5'd9);
    do_cycle("x9_same", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9, 5'd9);
    idle("x9_after", 5'd9, 5'd9, 5'd9, 5'd9);
    check("x9.literal", bus.RF_Rs1Data_1, 32'h2);

    // Random traffic with a bias toward same-rd collisions and x0 targets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a0, a1;
      a0 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      do_cycle("rand",
               1'($urandom), a0, $urandom,
               1'($urandom), a1, $urandom,
               5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end

    // Leave the flag set, then reset asynchronously between edges.
    do_cycle("pre_rst", 1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 5'd12, 32'h0BADF00D, 5'd12, 5'd3, 5'd4, 5'd5);
    set_reads(5'd12, 5'd3, 5'd4, 5'd5);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    coll_exp = 1'b0;
    check_reads("async_rst");
    check("async_rst.coll", 32'(bus.RF_WrtCollision), 32'h0);

    // Writes presented while reset is held must be discarded.
    bus.MemWb_RdWrtEn_0 = 1'b1; bus.MemWb_RdAddr_0 = 5'd20; bus.Wb_DataWrt_0 = 32'h77777777;
    bus.MemWb_RdWrtEn_1 = 1'b1; bus.MemWb_RdAddr_1 = 5'd21; bus.Wb_DataWrt_1 = 32'h88888888;
    @(posedge clk);
    @(negedge clk);
    bus.MemWb_RdWrtEn_0 = 1'b0;
    bus.MemWb_RdWrtEn_1 = 1'b0;
    rst_n = 1'b1;
    idle("post_rst", 5'd20, 5'd21, 5'd12, 5'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
